mux_nto1_rr: RTL and testbench

//  Parametrised N:1 multiplexer with a registered output and valid/ready handshakes.
//  Two modes: fixed select (channel chosen by sel) and round-robin arbitration across all requesting channels.

---
 rtl/mux_nto1_rr.sv | 102 ++++++++++
 tb/tb_mux_nto1_rr.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mux_nto1_rr.sv
// N:1 stream multiplexer with one output register stage, selectable fixed-select
// or round-robin arbitration, and valid/ready handshakes on both sides.
module mux_nto1_rr #(
    parameter int N     = 8,
    parameter int WIDTH = 8,
    localparam int SEL_W = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic               mode,
    input  logic [SEL_W-1:0]   sel,
    output logic [WIDTH-1:0]   out_data,
    output logic [SEL_W-1:0]   out_ch,
    output logic               out_valid,
    input  logic               out_ready
);

    logic [WIDTH-1:0] r_data;
    logic [SEL_W-1:0] r_ch;
    logic             r_valid;
    logic [SEL_W-1:0] r_ptr;

    logic             w_sel_ok;
    logic             w_load;
    logic             w_rr_hit;
    logic [SEL_W-1:0] w_rr_idx;
    logic             w_gnt_ok;
    logic [SEL_W-1:0] w_gnt;
    logic             w_xfer;
    logic [N-1:0]     w_ready;
    logic [SEL_W-1:0] w_ptr_nxt;
    int               w_j;

    // A select value can only be out of range when N is not a power of two.
    if ((1 << SEL_W) > N) begin : g_sel_chk
        assign w_sel_ok = (int'(sel) < N);
    end else begin : g_sel_full
        assign w_sel_ok = 1'b1;
    end

    // Reset also blocks the handshake so nothing is accepted while it is held.
    assign w_load = !rst && (!r_valid || out_ready);

    always_comb begin
        w_rr_hit = 1'b0;
        w_rr_idx = '0;
        w_j      = 0;
        for (int k = 0; k < N; k++) begin
            w_j = int'(r_ptr) + k;
            if (w_j >= N) w_j = w_j - N;
            if (!w_rr_hit && in_valid[w_j]) begin
                w_rr_hit = 1'b1;
                w_rr_idx = SEL_W'(w_j);
            end
        end
    end

    always_comb begin
        w_gnt_ok = 1'b0;
        w_gnt    = '0;
        if (mode) begin
            w_gnt_ok = w_rr_hit;
            w_gnt    = w_rr_idx;
        end else begin
            w_gnt_ok = w_sel_ok;
            w_gnt    = sel;
        end
    end

    always_comb begin
        w_ready = '0;
        if (w_load && w_gnt_ok) w_ready[w_gnt] = 1'b1;
    end

    assign w_xfer    = w_load && w_gnt_ok && in_valid[w_gnt];
    assign w_ptr_nxt = (int'(w_gnt) == N - 1) ? '0 : w_gnt + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_ch    <= '0;
            r_ptr   <= '0;
        end else if (w_xfer) begin
            r_valid <= 1'b1;
            r_data  <= in_data[w_gnt*WIDTH +: WIDTH];
            r_ch    <= w_gnt;
            if (mode) r_ptr <= w_ptr_nxt;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign in_ready  = w_ready;
    assign out_data  = r_data;
    assign out_ch    = r_ch;
    assign out_valid = r_valid;

endmodule

// File: tb/tb_mux_nto1_rr.sv
// Directed bench for mux_nto1_rr: an N=8 instance for the main sequences and an
// N=6 instance for out-of-range fixed selects.
module tb_mux_nto1_rr;

    logic        clk = 1'b0;
    logic        rst;

    logic [63:0] in_data;
    logic [7:0]  in_valid;
    logic [7:0]  in_ready;
    logic        mode;
    logic [2:0]  sel;
    logic [7:0]  out_data;
    logic [2:0]  out_ch;
    logic        out_valid;
    logic        out_ready;

    logic [47:0] in_data6;
    logic [5:0]  in_valid6;
    logic [5:0]  in_ready6;
    logic        mode6;
    logic [2:0]  sel6;
    logic [7:0]  out_data6;
    logic [2:0]  out_ch6;
    logic        out_valid6;
    logic        out_ready6;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mux_nto1_rr #(.N(8), .WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
        .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready)
    );

    mux_nto1_rr #(.N(6), .WIDTH(8)) u_dut6 (
        .clk(clk), .rst(rst), .in_data(in_data6), .in_valid(in_valid6),
        .in_ready(in_ready6), .mode(mode6), .sel(sel6), .out_data(out_data6),
        .out_ch(out_ch6), .out_valid(out_valid6), .out_ready(out_ready6)
    );

    typedef struct {
        logic [2:0] sel;
        logic [7:0] valid;
        logic [7:0] base;
        logic [7:0] exp_ready;
        logic       exp_ovalid;
        logic [7:0] exp_data;
        logic [2:0] exp_ch;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data8(input logic [7:0] base);
        for (int i = 0; i < 8; i++) in_data[i*8 +: 8] = base ^ 8'(i);
    endtask

    task automatic set_data6(input logic [7:0] base);
        for (int i = 0; i < 6; i++) in_data6[i*8 +: 8] = base ^ 8'(i);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{3'd5, 8'hFF, 8'hA0, 8'h20, 1'b1, 8'hA5, 3'd5};
        vecs[1] = '{3'd0, 8'h01, 8'h3C, 8'h01, 1'b1, 8'h3C, 3'd0};
        vecs[2] = '{3'd7, 8'h80, 8'h5A, 8'h80, 1'b1, 8'h5D, 3'd7};
        vecs[3] = '{3'd3, 8'hF7, 8'h00, 8'h08, 1'b0, 8'h00, 3'd0};
        vecs[4] = '{3'd2, 8'h04, 8'hFF, 8'h04, 1'b1, 8'hFD, 3'd2};

        // T1: reset with every input active
        rst = 1'b1; mode = 1'b1; sel = 3'd0; in_valid = 8'hFF; out_ready = 1'b1;
        set_data8(8'hA0);
        mode6 = 1'b1; sel6 = 3'd0; in_valid6 = 6'h3F; out_ready6 = 1'b1;
        set_data6(8'hA0);
        #1;
        chk("t1_ready_async", 64'(in_ready), 64'h0);
        for (int c = 0; c < 2; c++) begin
            tick();
            chk("t1_out_valid", 64'(out_valid), 64'h0);
            chk("t1_out_data", 64'(out_data), 64'h0);
            chk("t1_in_ready", 64'(in_ready), 64'h0);
        end

        // T3: N=6 fixed select out of range; the N=8 instance idles meanwhile
        in_valid = 8'h00; mode = 1'b0;
        mode6 = 1'b0; sel6 = 3'd7;
        rst = 1'b0;
        #1;
        chk("t3_ready_sel7", 64'(in_ready6), 64'h0);
        tick();
        chk("t3_ovalid_sel7", 64'(out_valid6), 64'h0);
        sel6 = 3'd6;
        #1;
        chk("t3_ready_sel6", 64'(in_ready6), 64'h0);
        tick();
        chk("t3_ovalid_sel6", 64'(out_valid6), 64'h0);
        sel6 = 3'd5;
        #1;
        chk("t3_ready_sel5", 64'(in_ready6), 64'h20);
        tick();
        chk("t3_ovalid_sel5", 64'(out_valid6), 64'h1);
        chk("t3_ch_sel5", 64'(out_ch6), 64'h5);
        chk("t3_data_sel5", 64'(out_data6), 64'hA5);

        // T2: fixed-select vectors, consumer always ready
        for (int v = 0; v < 5; v++) begin
            sel = vecs[v].sel; in_valid = vecs[v].valid;
            set_data8(vecs[v].base);
            #1;
            chk($sformatf("t2_ready[%0d]", v), 64'(in_ready), 64'(vecs[v].exp_ready));
            tick();
            chk($sformatf("t2_ovalid[%0d]", v), 64'(out_valid), 64'(vecs[v].exp_ovalid));
            if (vecs[v].exp_ovalid) begin
                chk($sformatf("t2_data[%0d]", v), 64'(out_data), 64'(vecs[v].exp_data));
                chk($sformatf("t2_ch[%0d]", v), 64'(out_ch), 64'(vecs[v].exp_ch));
            end
        end

        // T4: round-robin, all channels valid; pointer still 0 from reset
        mode = 1'b1; in_valid = 8'hFF; set_data8(8'hA0);
        for (int c = 0; c < 9; c++) begin
            tick();
            chk($sformatf("t4_ch[%0d]", c), 64'(out_ch), 64'(c % 8));
            chk($sformatf("t4_ovalid[%0d]", c), 64'(out_valid), 64'h1);
            chk($sformatf("t4_data[%0d]", c), 64'(out_data), 64'(8'hA0 | 8'(c % 8)));
        end

        // T5: ptr=1; a lone ch2 grant moves it to 3, then ch2/ch6 alternate from 6
        in_valid = 8'h04;
        #1;
        chk("t5_ready_pre", 64'(in_ready), 64'h04);
        tick();
        chk("t5_ch_pre", 64'(out_ch), 64'h2);
        in_valid = 8'h44;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk($sformatf("t5_ready[%0d]", c), 64'(in_ready), (c % 2 == 0) ? 64'h40 : 64'h04);
            tick();
            chk($sformatf("t5_ch[%0d]", c), 64'(out_ch), (c % 2 == 0) ? 64'h6 : 64'h2);
        end

        // T6: backpressure with ptr=3, then resume, then reset mid-stream
        in_valid = 8'hFF;
        tick();
        chk("t6_ch_first", 64'(out_ch), 64'h3);
        out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk($sformatf("t6_ready_hold[%0d]", c), 64'(in_ready), 64'h0);
            tick();
            chk($sformatf("t6_ovalid_hold[%0d]", c), 64'(out_valid), 64'h1);
            chk($sformatf("t6_ch_hold[%0d]", c), 64'(out_ch), 64'h3);
            chk($sformatf("t6_data_hold[%0d]", c), 64'(out_data), 64'hA3);
        end
        out_ready = 1'b1;
        #1;
        chk("t6_ready_resume", 64'(in_ready), 64'h10);
        tick();
        chk("t6_ch_resume", 64'(out_ch), 64'h4);
        chk("t6_data_resume", 64'(out_data), 64'hA4);
        tick();
        chk("t6_ch_next", 64'(out_ch), 64'h5);
        rst = 1'b1;
        #1;
        chk("t6_ready_in_rst", 64'(in_ready), 64'h0);
        tick();
        chk("t6_ovalid_rst", 64'(out_valid), 64'h0);
        rst = 1'b0;
        #1;
        chk("t6_ready_ptr0", 64'(in_ready), 64'h01);
        tick();
        chk("t6_ch_ptr0", 64'(out_ch), 64'h0);
        chk("t6_ovalid_after", 64'(out_valid), 64'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
